// File: rtl/serial_pkg.sv
// serial_pkg: framing constants and FSM encoding shared by the serial transmit and receive paths
package serial_pkg;
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t SHIFT = 2'd1;
   localparam state_t STOP = 2'd2;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: serial-in parallel-out capture register with selectable bit order
module sipo_shift_reg #(
   parameter int WIDTH = 4,
   parameter bit LSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or posedge clr)
      if (clr) q <= '0;
      else if (shift_en) q <= LSB_FIRST ? {din, q[WIDTH-1:1]} : {q[WIDTH-2:0], din};
endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: framed serial-to-parallel receiver with valid/ready output and error pulses
module serial_word_receiver
   import serial_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter bit LSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             serial_in,
   input  logic             out_ready,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);
   localparam int CW = $clog2(WIDTH + 1);
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] word;
   logic shifting, last_bit, in_stop, complete, load;
   assign shifting = state == SHIFT;
   assign last_bit = cnt == CW'(WIDTH - 1);
   assign in_stop = state == STOP;
   assign complete = in_stop && serial_in == STOP_BIT;
   // a finished word may replace the held one only if that one leaves on this same edge
   assign load = complete && (!out_valid || out_ready);
   assign busy = state != IDLE;
   always_comb
      state_nx = state == IDLE ? (serial_in == START_BIT ? SHIFT : IDLE)
               : shifting ? (last_bit ? STOP : SHIFT) : IDLE;
   sipo_shift_reg #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_sipo (
      .clk(clk),
      .clr(clr),
      .shift_en(shifting),
      .din(serial_in),
      .q(word)
   );
   always_ff @(posedge clk or posedge clr)
      if (clr) begin
         state <= IDLE;
         cnt <= '0;
         parallel_out <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= shifting ? cnt + 1'b1 : '0;
         if (load) parallel_out <= word;
         out_valid <= load || (out_valid && !out_ready);
         frame_err <= in_stop && serial_in != STOP_BIT;
         overrun <= complete && !load;
      end
endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-to-parallel receiver for the single-wire framed bit stream driven by the team's shift-register transmit path. Detects a start bit, shifts in `WIDTH` data bits at one bit per clock, and checks a stop bit. Presents each completed word on a registered parallel output with a valid/ready handshake. Sits between the serial link and any parallel consumer, and reports framing and overrun errors.

## Interface
- `WIDTH`, default 4: data bits per frame, ≥ 2.
- `LSB_FIRST`, default 0: 0 means the first data bit received is bit `WIDTH-1` (MSB first); 1 means the first data bit is bit 0.
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `clr`  in  1: reset, asynchronous, active-high; returns every register to its reset value immediately.
- `serial_in`  in  1: serial line; idles high (1).
- `out_ready`  in  1: consumer accepts the word when high while `out_valid` is high.
- `parallel_out`  out  WIDTH: last accepted word; reset 0.
- `out_valid`  out  1: `parallel_out` holds an unconsumed word; reset 0.
- `busy`  out  1: high in SHIFT and STOP states; reset 0.
- `frame_err`  out  1: one-cycle pulse, stop bit sampled as 0; reset 0.
- `overrun`  out  1: one-cycle pulse, a completed word was dropped; reset 0.

## Operation
- Frame format: start bit (0), then `WIDTH` data bits, then stop bit (1). One bit per `clk` cycle. No oversampling.
- FSM states: IDLE, SHIFT, STOP.
  - IDLE: `serial_in`=0 sampled → SHIFT with bit count 0. Otherwise stay in IDLE.
  - SHIFT: sample one data bit per cycle into the shift register and increment the count. After `WIDTH` bits → STOP.
  - STOP: sample the stop bit, then always return to IDLE.
- Bit order:
  - MSB first: shift left, new bit enters at bit 0.
  - LSB first: shift right, new bit enters at bit `WIDTH-1`.
- Stop bit = 1: the word completes.
  - If `out_valid`=0, or `out_valid`&`out_ready` in the same cycle: load `parallel_out`, set `out_valid`=1.
  - Otherwise: keep the old word, drop the new one, pulse `overrun`.
- Stop bit = 0: discard the word, pulse `frame_err`, do not touch the output. The 0 is not taken as a new start bit.
- Handshake: a transfer happens on an edge where `out_valid`&`out_ready`. `out_valid` clears on that edge unless a new word loads on the same edge.
- `parallel_out` is stable while `out_valid`=1 and is never cleared by a transfer.
- `out_ready` never affects reception. The shift path runs regardless of output backpressure.

## Timing
- Start bit sampled on edge E0; data bits on E1..E`WIDTH`; stop bit on E`WIDTH`+1.
- `out_valid`, `parallel_out`, `frame_err` and `overrun` all update on E`WIDTH`+1, so they are visible the cycle after the stop bit.
- Latency from start-bit edge to `out_valid` = `WIDTH`+1 cycles.
- Back-to-back frames: the next start bit can be sampled on E`WIDTH`+2, giving a sustained throughput of one word per `WIDTH`+2 cycles.
- `busy` is high from the cycle after E0 through the cycle that ends with E`WIDTH`+1.
- Error pulses last exactly one cycle.
- `clr` asserted mid-frame: the partial word is lost, the FSM returns to IDLE, and all outputs take their reset values without waiting for a clock. After deassertion, the first edge can detect a start bit.
- `serial_in` must meet setup/hold to `clk`. There is no synchronizer inside the block.

## Structure
- Shared package `serial_pkg`: FSM state typedef (IDLE/SHIFT/STOP) and constants `START_BIT`=0, `STOP_BIT`=1, `IDLE_LEVEL`=1. Reused by the matching transmitter.
- Sub-module `sipo_shift_reg` (parameters `WIDTH`, `LSB_FIRST`; ports `clk`, `clr`, `shift_en`, `din`, `q`): the capture register.
- Top level contains the FSM, the bit counter of width $clog2(`WIDTH`+1), the output register and the handshake logic.

## Test plan
- Basic frame, `WIDTH`=4, MSB first, `out_ready`=1: `serial_in` = 0,1,0,1,1,1 on consecutive edges → `parallel_out`=4'b1011 and `out_valid`=1 after the 6th edge; one-cycle valid.
- LSB first, same bit stream → `parallel_out`=4'b1101.
- Framing error: 0,1,1,1,1,0 → `frame_err` pulses one cycle, `out_valid` stays 0, and the FSM is in IDLE.
- Backpressure:
  - Hold `out_ready`=0. Send 4'b1011, then 4'b0110 back-to-back → `overrun` pulses on the second stop edge and `parallel_out` stays 4'b1011.
  - Then raise `out_ready` → `out_valid` drops after one edge.
  - Simultaneous case: `out_ready`=1 on the edge the second word completes → loads 4'b0110, `out_valid` stays 1, no `overrun`.
- Reset mid-frame: assert `clr` after 2 data bits → `busy`, `out_valid` and `parallel_out` go to 0 asynchronously. A clean frame 4'b0011 sent after release is received correctly.
- Idle line held at 1 for 20 cycles → no `out_valid`, no error pulses, `busy`=0.
